// File: rtl/morse_player.sv
// Morse transmitter: replays a dot/line code word MSB-first as a timed lamp/buzzer signal,
// one code bit per UNIT_CYCLES clocks, after skipping the word's leading zeros.
module morse_player #(
  parameter int WIDTH       = 20,
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] code,
  output logic             signal_out,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(UNIT_CYCLES) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_PLAY,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    signal_d = signal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        signal_d = 1'b0;
        busy_d   = 1'b0;
        if (start) begin
          sr_d    = code;
          idx_d   = IDX_LAST;
          busy_d  = 1'b1;
          state_d = S_SEEK;
        end
      end

      S_SEEK: begin
        if (sr_q[WIDTH-1]) begin
          signal_d = 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = S_PLAY;
        end else if (idx_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          sr_d  = sr_q << 1;
          idx_d = idx_q - 1'b1;
        end
      end

      S_PLAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q == '0) begin
          // last bit is the symbol's trailing 0, so the word ends with one off unit
          signal_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          sr_d     = sr_q << 1;
          idx_d    = idx_q - 1'b1;
          signal_d = sr_q[WIDTH-2];
          cnt_d    = CNT_LOAD;
        end
      end

      S_DONE: begin
        signal_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign signal_out = signal_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_morse_player.sv
// Bench for morse_player: per-cycle comparison of signal_out/busy/done against a
// timeline computed from the code word's leading-zero count and unit length.
module tb_morse_player;

  localparam int W = 20;
  localparam int U = 4;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] code = '0;
  logic         signal_out, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  morse_player #(.WIDTH(W), .UNIT_CYCLES(U)) dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .code(code),
    .signal_out(signal_out),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lead_zeros(input logic [W-1:0] c);
    int k = 0;
    while (k < W && c[W-1-k] == 1'b0) k++;
    return k;
  endfunction

  // cycles from the accepting edge until the edge that raises done
  function automatic int done_n(input logic [W-1:0] c);
    int k = lead_zeros(c);
    return (k == W) ? W : 1 + k + (W - k) * U;
  endfunction

  // expected {signal_out, busy, done} just after edge T+n
  function automatic logic [2:0] expect_at(input logic [W-1:0] c, input int n);
    int k = lead_zeros(c);
    int d = done_n(c);
    logic s = 1'b0;
    if (k < W && n >= 1 + k && n < d) s = c[W-1-k-(n-1-k)/U];
    return {s, (n < d), (n == d)};
  endfunction

  // mode 0: plain, 1: extra start at T+10, 2: reset at T+20, 3: start held into DONE
  task automatic play(input logic [W-1:0] c, input int mode, input string name);
    int d = done_n(c);
    logic [2:0] e;
    @(negedge clock);
    code  = c;
    start = 1'b1;
    @(posedge clock);
    for (int n = 0; n <= d + 1; n++) begin
      @(negedge clock);
      start = 1'b0;
      code  = W'($urandom);
      if (mode == 2 && n == 20) begin
        chk($sformatf("%s rst sig", name), 32'(signal_out), 32'd0);
        chk($sformatf("%s rst busy", name), 32'(busy), 32'd0);
        chk($sformatf("%s rst done", name), 32'(done), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk($sformatf("%s idle busy", name), 32'(busy), 32'd0);
        return;
      end
      e = expect_at(c, n);
      chk($sformatf("%s sig n=%0d", name, n), 32'(signal_out), 32'(e[2]));
      chk($sformatf("%s busy n=%0d", name, n), 32'(busy), 32'(e[1]));
      chk($sformatf("%s done n=%0d", name, n), 32'(done), 32'(e[0]));
      if (mode == 1 && n == 9) start = 1'b1;
      if (mode == 2 && n == 19) resetn = 1'b0;
      if (mode == 3 && n == d) start = 1'b1;
    end
    @(negedge clock);
    chk($sformatf("%s idle busy", name), 32'(busy), 32'd0);
    chk($sformatf("%s idle sig", name), 32'(signal_out), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rc;
    int k;
    repeat (3) @(negedge clock);
    chk("reset sig", 32'(signal_out), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    // start held during reset must not be taken
    start = 1'b1;
    code  = 20'hFFFFF;
    @(negedge clock);
    chk("reset vs start busy", 32'(busy), 32'd0);
    start  = 1'b0;
    resetn = 1'b1;
    @(negedge clock);

    play(20'h00002, 0, "dot");
    play(20'h0002E, 0, "dotline");
    play(20'h00000, 0, "zero");
    play(20'hFFFFF, 3, "ones");
    play(20'h0000E, 1, "restart");
    play(20'h0000E, 2, "reset");
    play(20'h002BA, 0, "after_reset");

    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, W);
      if (k == W) rc = '0;
      else rc = (W'($urandom) & W'((32'd1 << (W - k)) - 1)) | W'(32'd1 << (W - 1 - k));
      play(rc, 0, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
